vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates the 800x600@60Hz VGA raster timing (40 MHz pixel rate) for the Display stage.
//  Provides the pixel coordinates used by the board renderer to look up colour.
//  Provides HS/VS/active, delayed to line up with the renderer's pipeline, so Display can
//  gate R/G/B and drive the connector.
//  Sits directly upstream of Display.
// PARAMETERS
//  H_VIS      800   visible pixels per line
//  H_FP       40    horizontal front porch, pixels
//  H_SYNC     128   horizontal sync width, pixels
//  H_BP       88    horizontal back porch, pixels (H_TOTAL = 1056)
//  V_VIS      600   visible lines per frame
//  V_FP       1     vertical front porch, lines
//  V_SYNC     4     vertical sync width, lines
//  V_BP       23    vertical back porch, lines (V_TOTAL = 628)
//  SYNC_POL   1     asserted level of hsync/vsync (1 = positive, as 800x600@60 requires)
//  PIPE_DLY   2     extra cycles of delay on hsync/vsync/active; range 0..7
// PORTS
//  clk          in   1   pixel clock, 40 MHz; all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  ce           in   1   pixel enable; when 0, all state (counters, delay line) holds
//  hcount       out  11  current pixel column, 0..H_TOTAL-1
//  vcount       out  10  current line, 0..V_TOTAL-1
//  line_start   out  1   1-cycle pulse, high while hcount==0 and ce==1
//  frame_start  out  1   1-cycle pulse, high while hcount==0, vcount==0 and ce==1
//  hsync        out  1   horizontal sync, delayed PIPE_DLY ce-cycles
//  vsync        out  1   vertical sync, delayed PIPE_DLY ce-cycles
//  active       out  1   visible-area flag, delayed PIPE_DLY ce-cycles
// BEHAVIOUR
//  - Reset values: hcount=0, vcount=0, active=0, hsync=vsync=~SYNC_POL.
//    All PIPE_DLY delay stages load the inactive levels.
//    rst has priority over ce.
//  - Counters advance on each clk with ce=1:
//    - hcount += 1.
//    - At hcount==H_TOTAL-1: hcount wraps to 0 and vcount += 1.
//    - At vcount==V_TOTAL-1 on that same edge: vcount also wraps to 0.
//  - Undelayed raw flags, decoded combinationally from the counters:
//    - act_raw = (hcount<H_VIS) && (vcount<V_VIS).
//    - hs_raw asserted for H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC, i.e. 840..967.
//    - vs_raw asserted for V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC, i.e. 601..604,
//      for whole lines.
//  - Output alignment:
//    - hsync/vsync/active are registered.
//    - Each output equals its raw value from PIPE_DLY+1 ce-cycles earlier.
//    - hcount/vcount/line_start/frame_start are not delayed.
//    - With PIPE_DLY=0, hsync rises on the edge after the one where hcount becomes 840.
//  - ce low: counters, outputs and delay line are frozen; line_start/frame_start forced 0.
//  - Reset mid-frame: the next cycle shows hcount=vcount=0 and all delayed outputs inactive.
//    - The first post-reset active=1 appears PIPE_DLY+1 ce-cycles after reset release.
//    - No partial sync pulse is emitted.
//  - Width rule: counter compares are done at full counter width. Parameters must satisfy:
//    - H_TOTAL <= 2048
//    - V_TOTAL <= 1024
// TESTING
//  1. Hold rst 3 cycles with ce=1.
//     -> hcount=0, vcount=0, hsync=0, vsync=0, active=0.
//     -> frame_start=1 on the first cycle after release.
//  2. Free-run one line, ce=1, PIPE_DLY=2.
//     -> hsync high for exactly 128 consecutive cycles, first high when hcount==843.
//     -> active high for 800 cycles on line 0.
//  3. Run to hcount=1055, vcount=627.
//     -> Next edge: hcount=0, vcount=0, frame_start pulse.
//     -> frame_start period is exactly 1056*628 = 663168 cycles.
//  4. Check vsync across a frame.
//     -> vsync high over exactly 4*1056 cycles.
//     -> First high 3 cycles after the edge where vcount becomes 601.
//  5. Toggle ce 1,0,1,0.
//     -> hcount advances only on ce=1 edges.
//     -> hsync pulse still spans 128 ce=1 cycles.
//     -> line_start never high while ce=0.
//  6. Assert rst at hcount=900, vcount=300, i.e. mid-hsync.
//     -> hsync low on the next cycle.
//     -> Counters at 0.
//     -> Normal timing resumes from (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator, 800x600@60Hz (40 MHz pixel clock) by default.
//
// The counters give the current raster position and are never delayed.
// hsync/vsync/active are decoded from the counters and then pass through a register
// chain PIPE_DLY+1 stages long, so they line up with a renderer pipeline that is
// PIPE_DLY cycles deep.
//
// Ports:
//   clk_i          pixel clock; all state changes on the rising edge
//   rst_i          synchronous active-high reset; takes priority over ce_i
//   ce_i           pixel enable; when low, counters and the delay line hold
//   hcount_o       current pixel column, 0..H_TOTAL-1
//   vcount_o       current line, 0..V_TOTAL-1
//   line_start_o   high while hcount_o==0 and ce_i==1
//   frame_start_o  high while hcount_o==0, vcount_o==0 and ce_i==1
//   hsync_o        horizontal sync, asserted level SYNC_POL, delayed
//   vsync_o        vertical sync, asserted level SYNC_POL, delayed
//   active_o       visible-area flag, delayed
//
// Parameters must keep H_TOTAL <= 2048 and V_TOTAL <= 1024 (counter widths), and
// PIPE_DLY in 0..7.

module vga_timing_gen #(
  parameter int unsigned H_VIS    = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_VIS    = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  output logic [10:0] hcount_o,
  output logic [9:0]  vcount_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        active_o
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Compare constants at full counter width.
  localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0] HVisEnd  = 11'(H_VIS);
  localparam logic [10:0] HsStart  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HsEnd    = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VVisEnd  = 10'(V_VIS);
  localparam logic [9:0]  VsStart  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VsEnd    = 10'(V_VIS + V_FP + V_SYNC);

  localparam logic [PIPE_DLY:0] SyncIdle = {(PIPE_DLY + 1){~SYNC_POL}};

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;

  // Stage 0 takes the raw decode; stage PIPE_DLY drives the output.
  logic [PIPE_DLY:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DLY:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DLY:0] act_pipe_q, act_pipe_d;

  logic act_raw, hs_raw, vs_raw;
  logic hs_lvl, vs_lvl;

  // Extended vectors let one constant slice express the shift for any PIPE_DLY,
  // including zero.
  logic [PIPE_DLY+1:0] hs_ext, vs_ext, act_ext;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (ce_i) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        if (vcount_q == VLast) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  always_comb begin
    act_raw = (hcount_q < HVisEnd) && (vcount_q < VVisEnd);
    hs_raw  = (hcount_q >= HsStart) && (hcount_q < HsEnd);
    vs_raw  = (vcount_q >= VsStart) && (vcount_q < VsEnd);
    hs_lvl  = hs_raw ? SYNC_POL : ~SYNC_POL;
    vs_lvl  = vs_raw ? SYNC_POL : ~SYNC_POL;
  end

  always_comb begin
    hs_ext     = {hs_pipe_q, hs_lvl};
    vs_ext     = {vs_pipe_q, vs_lvl};
    act_ext    = {act_pipe_q, act_raw};
    hs_pipe_d  = hs_pipe_q;
    vs_pipe_d  = vs_pipe_q;
    act_pipe_d = act_pipe_q;
    if (ce_i) begin
      hs_pipe_d  = hs_ext[PIPE_DLY:0];
      vs_pipe_d  = vs_ext[PIPE_DLY:0];
      act_pipe_d = act_ext[PIPE_DLY:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      hs_pipe_q  <= SyncIdle;
      vs_pipe_q  <= SyncIdle;
      act_pipe_q <= '0;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      act_pipe_q <= act_pipe_d;
    end
  end

  always_comb begin
    hcount_o      = hcount_q;
    vcount_o      = vcount_q;
    line_start_o  = ce_i && (hcount_q == 11'd0);
    frame_start_o = ce_i && (hcount_q == 11'd0) && (vcount_q == 10'd0);
    hsync_o       = hs_pipe_q[PIPE_DLY];
    vsync_o       = vs_pipe_q[PIPE_DLY];
    active_o      = act_pipe_q[PIPE_DLY];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance plus a small-raster instance
// (negative sync, no extra delay) so that frame-level behaviour fits in a short run.
// Both are compared every cycle against a model that derives all outputs from the
// number of enabled clock edges since the last reset.

module tb_vga_timing_gen;

  // Small raster: 32 x 12, sync active low, PIPE_DLY = 0.
  localparam int SH_VIS = 20, SH_FP = 3, SH_SYNC = 5, SH_BP = 4;
  localparam int SV_VIS = 6, SV_FP = 1, SV_SYNC = 2, SV_BP = 3;
  localparam int SHT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
  localparam int SVT = SV_VIS + SV_FP + SV_SYNC + SV_BP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  logic [10:0] h_d, h_s;
  logic [9:0]  v_d, v_s;
  logic ls_d, fs_d, hs_d, vs_d, act_d;
  logic ls_s, fs_s, hs_s, vs_s, act_s;

  vga_timing_gen u_def (
    .clk_i        (clk),
    .rst_i        (rst),
    .ce_i         (ce),
    .hcount_o     (h_d),
    .vcount_o     (v_d),
    .line_start_o (ls_d),
    .frame_start_o(fs_d),
    .hsync_o      (hs_d),
    .vsync_o      (vs_d),
    .active_o     (act_d)
  );

  vga_timing_gen #(
    .H_VIS   (SH_VIS),
    .H_FP    (SH_FP),
    .H_SYNC  (SH_SYNC),
    .H_BP    (SH_BP),
    .V_VIS   (SV_VIS),
    .V_FP    (SV_FP),
    .V_SYNC  (SV_SYNC),
    .V_BP    (SV_BP),
    .SYNC_POL(1'b0),
    .PIPE_DLY(0)
  ) u_sml (
    .clk_i        (clk),
    .rst_i        (rst),
    .ce_i         (ce),
    .hcount_o     (h_s),
    .vcount_o     (v_s),
    .line_start_o (ls_s),
    .frame_start_o(fs_s),
    .hsync_o      (hs_s),
    .vsync_o      (vs_s),
    .active_o     (act_s)
  );

  always #5 clk = ~clk;

  logic [25:0] got_def, got_sml;
  assign got_def = {h_d, v_d, ls_d, fs_d, hs_d, vs_d, act_d};
  assign got_sml = {h_s, v_s, ls_s, fs_s, hs_s, vs_s, act_s};

  int n_pass  = 0;
  int n_total = 0;
  int t       = 0;   // enabled edges since last reset
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) t <= 0;
    else if (ce) t <= t + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", name, got, exp, t, $time);
  endtask

  // Raster position after tt enabled edges; delayed outputs reflect position tt-dly-1.
  function automatic logic [25:0] model_vec(input int ht, input int hvis, input int hfp,
                                            input int hsw, input int vt, input int vvis,
                                            input int vfp, input int vsw, input bit pol,
                                            input int dly, input int tt, input bit ce_now);
    int h, v, u, uh, uv;
    bit ls, fs, hs, vs, act;
    h   = tt % ht;
    v   = (tt / ht) % vt;
    ls  = ce_now && (h == 0);
    fs  = ls && (v == 0);
    hs  = ~pol;
    vs  = ~pol;
    act = 1'b0;
    if (tt >= dly + 1) begin
      u   = tt - dly - 1;
      uh  = u % ht;
      uv  = (u / ht) % vt;
      act = (uh < hvis) && (uv < vvis);
      if (uh >= hvis + hfp && uh < hvis + hfp + hsw) hs = pol;
      if (uv >= vvis + vfp && uv < vvis + vfp + vsw) vs = pol;
    end
    return {h[10:0], v[9:0], ls, fs, hs, vs, act};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_def", 32'(got_def),
            32'(model_vec(1056, 800, 40, 128, 628, 600, 1, 4, 1'b1, 2, t, ce)));
      check("model_sml", 32'(got_sml),
            32'(model_vec(SHT, SH_VIS, SH_FP, SH_SYNC, SVT, SV_VIS, SV_FP, SV_SYNC, 1'b0, 0,
                          t, ce)));
    end
  end

  // Drive inputs, take one edge, settle 2 time units past it.
  task automatic tick(input bit r, input bit c);
    rst = r;
    ce  = c;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
  endtask

  typedef struct {
    bit rst;
    bit ce;
    int h;
    int v;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
    bit act;
    bit chk_pre;
    bit pre_fs;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int hs_cnt, act_cnt, run, max_run, first_h, ls_bad, ls_on, hs_ce_cnt;
    int ft1, ft2, v7_k, first_vs_k, vs_cnt, first_hs_h, prev_v;
    logic [25:0] exp;

    //          rst ce  h  v  ls fs hs vs act pre pre_fs
    tbl[0]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    tbl[2]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};  // release: frame_start before edge
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0};  // active after PIPE_DLY+1 edges
    tbl[7]  = '{0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};  // rst beats ce=0
    tbl[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};

    // Table vectors on the default instance.
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      ce  = tbl[i].ce;
      #1;
      if (tbl[i].chk_pre) check($sformatf("tbl%0d_pre_fs", i), 32'(fs_d), 32'(tbl[i].pre_fs));
      @(posedge clk);
      #2;
      if (i == 0) chk_en = 1'b1;
      exp = {11'(tbl[i].h), 10'(tbl[i].v), tbl[i].ls, tbl[i].fs, tbl[i].hs, tbl[i].vs,
             tbl[i].act};
      check($sformatf("tbl%0d", i), 32'(got_def), 32'(exp));
    end

    // One free-running line.
    do_reset();
    hs_cnt = 0; act_cnt = 0; run = 0; max_run = 0; first_h = -1;
    for (int k = 1; k <= 1056; k++) begin
      tick(1'b0, 1'b1);
      if (act_d) act_cnt++;
      if (hs_d) begin
        hs_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (first_h < 0) first_h = int'(h_d);
      end else begin
        run = 0;
      end
    end
    check("line_hs_count", 32'(hs_cnt), 32'd128);
    check("line_hs_run", 32'(max_run), 32'd128);
    check("line_hs_first_h", 32'(first_h), 32'd843);
    check("line_active_count", 32'(act_cnt), 32'd800);

    // Alternating ce.
    do_reset();
    ls_bad = 0; ls_on = 0; hs_ce_cnt = 0;
    for (int k = 0; k < 2200; k++) begin
      tick(1'b0, (k % 2) == 0);
      if (!ce && ls_d) ls_bad++;
      if (ce && ls_d) ls_on++;
      if (ce && hs_d) hs_ce_cnt++;
    end
    check("ce_hcount", 32'(h_d), 32'd44);
    check("ce_vcount", 32'(v_d), 32'd1);
    check("ce_hs_count", 32'(hs_ce_cnt), 32'd128);
    check("ce_ls_while_low", 32'(ls_bad), 32'd0);
    check("ce_ls_pulses", 32'(ls_on), 32'd1);

    // Reset in the middle of hsync.
    do_reset();
    for (int k = 0; k < 900; k++) tick(1'b0, 1'b1);
    check("mid_hs_before", 32'(hs_d), 32'd1);
    tick(1'b1, 1'b1);
    check("mid_hs_after", 32'(hs_d), 32'd0);
    check("mid_counters", 32'({h_d, v_d}), 32'd0);
    first_h = -1;
    for (int k = 0; k < 1056; k++) begin
      tick(1'b0, 1'b1);
      if (hs_d && first_h < 0) first_h = int'(h_d);
    end
    check("mid_resume_hs_first_h", 32'(first_h), 32'd843);

    // Frame-level behaviour on the small raster.
    do_reset();
    ft1 = -1; ft2 = -1; v7_k = -1; first_vs_k = -1; vs_cnt = 0; first_hs_h = -1;
    prev_v = 0;
    for (int k = 1; k <= 800; k++) begin
      tick(1'b0, 1'b1);
      if (k == SHT * SVT - 1) check("sml_last_pos", 32'({h_s, v_s}), {11'd31, 10'd11});
      if (k == SHT * SVT) check("sml_wrap", 32'({h_s, v_s, fs_s}), 32'(1));
      if (fs_s) begin
        if (ft1 < 0) ft1 = k;
        else if (ft2 < 0) ft2 = k;
      end
      if (int'(v_s) == SV_VIS + SV_FP && prev_v == SV_VIS + SV_FP - 1 && v7_k < 0) v7_k = k;
      prev_v = int'(v_s);
      if (!vs_s && first_vs_k < 0) first_vs_k = k;
      if (!vs_s && k <= SHT * SVT) vs_cnt++;
      if (!hs_s && first_hs_h < 0) first_hs_h = int'(h_s);
    end
    check("sml_first_frame", 32'(ft1), 32'(SHT * SVT));
    check("sml_frame_period", 32'(ft2 - ft1), 32'(SHT * SVT));
    check("sml_vs_count", 32'(vs_cnt), 32'(SV_SYNC * SHT));
    check("sml_vs_lag", 32'(first_vs_k - v7_k), 32'd1);
    check("sml_hs_first_h", 32'(first_hs_h), 32'(SH_VIS + SH_FP + 1));

    // Randomized enable and occasional reset, checked against the model every cycle.
    for (int k = 0; k < 5000; k++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
